// File: rtl/ulx3s_clk_reset_sequencer.sv
// ULX3S clock/reset sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the downstream domain resets one by one. Lock loss or a soft
// reset request tears everything down again.

// One downstream domain reset bit. Clear wins over set; once set the bit
// stays high until cleared.
module ulx3s_crs_lane (
  input  logic clkin,
  input  logic rstn,
  input  logic clr,
  input  logic set,
  output logic rel_q
);
  logic rel_d;

  // next value of the released flag
  always_comb begin
    rel_d = rel_q;
    if (clr)      rel_d = 1'b0;
    else if (set) rel_d = 1'b1;
  end

  // released flag register
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) rel_q <= 1'b0;
    else       rel_q <= rel_d;
  end
endmodule

module ulx3s_clk_reset_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGGER        = 8
) (
  input  logic                 clkin,
  input  logic                 rstn,
  input  logic                 pll_locked,
  input  logic                 soft_rst,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rstn,
  output logic                 ready,
  output logic [7:0]           fail_count,
  output logic [2:0]           state
);
  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  // One shared counter; it only ever reaches (largest parameter - 1).
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE > STAGGER) ? LOCK_STABLE : STAGGER;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PRC_M1 = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_M1  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LS_M1  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] ST_M1  = CW'(STAGGER - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           fail_q, fail_d;
  logic [1:0]           sync_q, sync_d;
  logic                 lock_s;
  logic                 fail_inc, clr, first, step;
  logic [N_DOMAINS-1:0] rel_q, set;

  assign sync_d = {sync_q[0], pll_locked};
  assign lock_s = sync_q[1];

  // FSM next state, shared counter and domain release controls
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fail_inc = 1'b0;
    clr      = 1'b0;
    first    = 1'b0;
    step     = 1'b0;
    case (state_q)
      S_PLL_RESET: begin
        clr = 1'b1;
        if (cnt_q == PRC_M1) begin state_d = S_WAIT_LOCK; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      S_WAIT_LOCK: begin
        clr = 1'b1;
        if (lock_s) begin state_d = S_STABLE; cnt_d = '0; end
        else if (cnt_q == LT_M1) begin
          state_d = S_PLL_RESET; cnt_d = '0; fail_inc = 1'b1;
        end
        else cnt_d = cnt_q + CW'(1);
      end
      S_STABLE: begin
        clr = 1'b1;
        if (!lock_s) begin state_d = S_WAIT_LOCK; cnt_d = '0; end
        else if (cnt_q == LS_M1) begin
          state_d = S_RELEASE; cnt_d = '0; clr = 1'b0; first = 1'b1;
        end
        else cnt_d = cnt_q + CW'(1);
      end
      S_RELEASE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK; cnt_d = '0; clr = 1'b1; fail_inc = 1'b1;
        end
        else if (&rel_q) begin state_d = S_RUN; cnt_d = '0; end
        else if (cnt_q == ST_M1) begin step = 1'b1; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK; cnt_d = '0; clr = 1'b1; fail_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RESET; cnt_d = '0; clr = 1'b1;
      end
    endcase
    // soft reset overrides everything except an in-progress PLL reset;
    // a simultaneous lock loss still counts as a failure
    if (soft_rst && state_q != S_PLL_RESET) begin
      state_d = S_PLL_RESET;
      cnt_d   = '0;
      clr     = 1'b1;
      first   = 1'b0;
      step    = 1'b0;
    end
    fail_d = (fail_inc && fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
  end

  // state, counter, failure count and lock synchroniser registers
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_PLL_RESET;
      cnt_q   <= '0;
      fail_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      sync_q  <= sync_d;
    end
  end

  // domain i releases on the stagger tick after domain i-1 is already high
  for (genvar i = 0; i < N_DOMAINS; i++) begin : g_lane
    if (i == 0) begin : g_first
      assign set[i] = first;
    end else begin : g_next
      assign set[i] = step & rel_q[i-1];
    end
    ulx3s_crs_lane u_lane (
      .clkin (clkin),
      .rstn  (rstn),
      .clr   (clr),
      .set   (set[i]),
      .rel_q (rel_q[i])
    );
  end

  assign domain_rstn = rel_q;
  assign pll_rst     = (state_q == S_PLL_RESET);
  assign ready       = (state_q == S_RUN);
  assign fail_count  = fail_q;
  assign state       = state_q;
endmodule

// File: tb/tb_ulx3s_clk_reset_sequencer.sv
// Directed bench for ulx3s_clk_reset_sequencer with small parameters.
module tb_ulx3s_clk_reset_sequencer;
  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rstn;
  logic       ready;
  logic [7:0] fail_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  ulx3s_clk_reset_sequencer #(
    .N_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .LOCK_STABLE(8), .STAGGER(2)
  ) dut (
    .clkin(clkin), .rstn(rstn), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .domain_rstn(domain_rstn), .ready(ready),
    .fail_count(fail_count), .state(state)
  );

  always #5 clkin = ~clkin;

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
    ticks(3);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    n_cmp++; if (domain_rstn !== 3'b000 || ready !== 1'b0 || fail_count !== 8'd0) begin
      n_bad++; $display("FAIL rst_outs dom=%b rdy=%b fail=%0d exp 000/0/0", domain_rstn, ready, fail_count); end
    rstn = 1'b1;
    ticks(3);
    n_cmp++; if (state !== 3'd0 || pll_rst !== 1'b1) begin
      n_bad++; $display("FAIL pllrst_hold state=%0d pll_rst=%b exp 0/1", state, pll_rst); end
    tick();
    n_cmp++; if (state !== 3'd1 || pll_rst !== 1'b0) begin
      n_bad++; $display("FAIL pllrst_end state=%0d pll_rst=%b exp 1/0", state, pll_rst); end
  endtask

  task automatic test_nominal;
    pll_locked = 1'b1;
    ticks(2);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL nom_sync state=%0d exp=1", state); end
    tick();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL nom_stable state=%0d exp=2", state); end
    ticks(7);
    n_cmp++; if (state !== 3'd2 || domain_rstn !== 3'b000) begin
      n_bad++; $display("FAIL nom_prerel state=%0d dom=%b exp 2/000", state, domain_rstn); end
    tick();
    n_cmp++; if (state !== 3'd3 || domain_rstn !== 3'b001) begin
      n_bad++; $display("FAIL nom_rel0 state=%0d dom=%b exp 3/001", state, domain_rstn); end
    tick();
    n_cmp++; if (domain_rstn !== 3'b001) begin n_bad++; $display("FAIL nom_hold0 dom=%b exp=001", domain_rstn); end
    tick();
    n_cmp++; if (domain_rstn !== 3'b011) begin n_bad++; $display("FAIL nom_rel1 dom=%b exp=011", domain_rstn); end
    ticks(2);
    n_cmp++; if (domain_rstn !== 3'b111 || ready !== 1'b0 || state !== 3'd3) begin
      n_bad++; $display("FAIL nom_rel2 dom=%b rdy=%b state=%0d exp 111/0/3", domain_rstn, ready, state); end
    tick();
    n_cmp++; if (state !== 3'd4 || ready !== 1'b1 || domain_rstn !== 3'b111 || fail_count !== 8'd0) begin
      n_bad++; $display("FAIL nom_run state=%0d rdy=%b dom=%b fail=%0d exp 4/1/111/0", state, ready, domain_rstn, fail_count); end
  endtask

  task automatic test_lock_loss_run;
    pll_locked = 1'b0;
    ticks(2);
    n_cmp++; if (state !== 3'd4 || ready !== 1'b1) begin
      n_bad++; $display("FAIL loss_early state=%0d rdy=%b exp 4/1", state, ready); end
    tick();
    n_cmp++; if (state !== 3'd1 || ready !== 1'b0 || domain_rstn !== 3'b000 || fail_count !== 8'd1) begin
      n_bad++; $display("FAIL loss_drop state=%0d rdy=%b dom=%b fail=%0d exp 1/0/000/1", state, ready, domain_rstn, fail_count); end
  endtask

  task automatic test_glitch_stable;
    pll_locked = 1'b1;
    ticks(6);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL gl_stable state=%0d exp=2", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL gl_drop state=%0d exp=1", state); end
    tick();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL gl_relock state=%0d exp=2", state); end
    ticks(7);
    n_cmp++; if (state !== 3'd2 || domain_rstn !== 3'b000) begin
      n_bad++; $display("FAIL gl_prerel state=%0d dom=%b exp 2/000", state, domain_rstn); end
    tick();
    n_cmp++; if (state !== 3'd3 || domain_rstn !== 3'b001 || fail_count !== 8'd1) begin
      n_bad++; $display("FAIL gl_rel state=%0d dom=%b fail=%0d exp 3/001/1", state, domain_rstn, fail_count); end
  endtask

  task automatic test_soft_release;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    n_cmp++; if (state !== 3'd0 || domain_rstn !== 3'b000 || pll_rst !== 1'b1 || ready !== 1'b0) begin
      n_bad++; $display("FAIL soft_drop state=%0d dom=%b pll_rst=%b exp 0/000/1", state, domain_rstn, pll_rst); end
    ticks(3);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL soft_pllrst state=%0d exp=0", state); end
    tick();
    n_cmp++; if (state !== 3'd1 || pll_rst !== 1'b0) begin
      n_bad++; $display("FAIL soft_wait state=%0d pll_rst=%b exp 1/0", state, pll_rst); end
    tick();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL soft_stable state=%0d exp=2", state); end
    ticks(8);
    n_cmp++; if (state !== 3'd3 || domain_rstn !== 3'b001) begin
      n_bad++; $display("FAIL soft_rel0 state=%0d dom=%b exp 3/001", state, domain_rstn); end
    ticks(2);
    n_cmp++; if (domain_rstn !== 3'b011) begin n_bad++; $display("FAIL soft_rel1 dom=%b exp=011", domain_rstn); end
    ticks(2);
    n_cmp++; if (domain_rstn !== 3'b111) begin n_bad++; $display("FAIL soft_rel2 dom=%b exp=111", domain_rstn); end
    tick();
    n_cmp++; if (state !== 3'd4 || ready !== 1'b1) begin
      n_bad++; $display("FAIL soft_run state=%0d rdy=%b exp 4/1", state, ready); end
  endtask

  task automatic test_async_reset;
    rstn = 1'b0;
    #2;
    n_cmp++; if (state !== 3'd0 || pll_rst !== 1'b1 || domain_rstn !== 3'b000 || ready !== 1'b0 || fail_count !== 8'd0) begin
      n_bad++; $display("FAIL async_rst state=%0d pll_rst=%b dom=%b rdy=%b fail=%0d exp 0/1/000/0/0",
                        state, pll_rst, domain_rstn, ready, fail_count); end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_soft_and_loss;
    int waited;
    waited = 0;
    while (state !== 3'd4 && waited < 60) begin tick(); waited++; end
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL sl_reach_run state=%0d exp=4 (timeout)", state); end
    pll_locked = 1'b0;
    ticks(2);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    n_cmp++; if (state !== 3'd0 || fail_count !== 8'd1 || domain_rstn !== 3'b000 || ready !== 1'b0) begin
      n_bad++; $display("FAIL sl_both state=%0d fail=%0d dom=%b rdy=%b exp 0/1/000/0", state, fail_count, domain_rstn, ready); end
  endtask

  task automatic test_timeout;
    rstn = 1'b0; pll_locked = 1'b0;
    ticks(2);
    rstn = 1'b1;
    tick();
    soft_rst = 1'b1;            // must be ignored while in PLL reset
    tick();
    soft_rst = 1'b0;
    ticks(2);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL to_soft_ignored state=%0d exp=1", state); end
    ticks(31);
    n_cmp++; if (state !== 3'd1 || fail_count !== 8'd0) begin
      n_bad++; $display("FAIL to_pre state=%0d fail=%0d exp 1/0", state, fail_count); end
    tick();
    n_cmp++; if (state !== 3'd0 || pll_rst !== 1'b1 || fail_count !== 8'd1) begin
      n_bad++; $display("FAIL to_first state=%0d pll_rst=%b fail=%0d exp 0/1/1", state, pll_rst, fail_count); end
    ticks(4);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL to_retry state=%0d exp=1", state); end
    ticks(32);
    n_cmp++; if (state !== 3'd0 || fail_count !== 8'd2) begin
      n_bad++; $display("FAIL to_second state=%0d fail=%0d exp 0/2", state, fail_count); end
    ticks(36*255 - 1 - 72);
    n_cmp++; if (fail_count !== 8'd254) begin n_bad++; $display("FAIL to_254 fail=%0d exp=254", fail_count); end
    tick();
    n_cmp++; if (fail_count !== 8'd255) begin n_bad++; $display("FAIL to_255 fail=%0d exp=255", fail_count); end
    ticks(36*3);
    n_cmp++; if (fail_count !== 8'd255 || state !== 3'd0) begin
      n_bad++; $display("FAIL to_sat fail=%0d state=%0d exp 255/0", fail_count, state); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_run();
    test_glitch_stable();
    test_soft_release();
    test_async_reset();
    test_soft_and_loss();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ulx3s_clk_reset_sequencer.md
ULX3S_CLK_RESET_SEQUENCER -- requirements
Module: ulx3s_clk_reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 4, number of downstream clock domains (1..16).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held high per attempt (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536, cycles allowed for lock per attempt (>=2).
REQ-004 SHALL have parameter LOCK_STABLE, default 1024, consecutive locked cycles required before release (>=1).
REQ-005 SHALL have parameter STAGGER, default 8, cycles between successive domain reset releases (>=1).
REQ-006 SHALL have port clkin  input  1  25 MHz reference clock; the only clock of the block.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port pll_locked  input  1  PLL LOCK, asynchronous to clkin.
REQ-009 SHALL have port soft_rst  input  1  synchronous single-cycle request to re-sequence.
REQ-010 SHALL have port pll_rst  output  1  drives PLL RST, active-high.
REQ-011 SHALL have port domain_rstn  output  N_DOMAINS  per-domain reset, active-low, clkin-registered.
REQ-012 SHALL have port ready  output  1  all domains released and lock held.
REQ-013 SHALL have port fail_count  output  8  saturating count of timeouts plus lock losses.
REQ-014 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-015 SHALL synchronise pll_locked through a 2-flop chain; "lock_s" below is the synchronised value (2-cycle latency).
REQ-016 SHALL implement states PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4; other encodings SHALL go to PLL_RESET next cycle.
REQ-017 PLL_RESET: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with pll_rst=0.
REQ-018 WAIT_LOCK: lock_s=1 -> STABLE; LOCK_TIMEOUT cycles without lock_s -> PLL_RESET, fail_count+1.
REQ-019 STABLE: LOCK_STABLE consecutive cycles lock_s=1 -> RELEASE; any lock_s=0 -> WAIT_LOCK with timeout counter restarted, no fail_count change.
REQ-020 RELEASE: domain_rstn[0] goes high on first RELEASE cycle; domain_rstn[i] goes high STAGGER cycles after domain_rstn[i-1]; after domain_rstn[N_DOMAINS-1] rises, next cycle -> RUN.
REQ-021 RUN: ready=1; ready SHALL be 0 in every other state.
REQ-022 lock_s=0 in RELEASE or RUN SHALL, on the next clock, drive all domain_rstn=0, ready=0, state WAIT_LOCK, fail_count+1.
REQ-023 soft_rst=1 in any state except PLL_RESET SHALL, next clock, drive all domain_rstn=0, ready=0, state PLL_RESET with fresh PLL_RST_CYCLES count; soft_rst SHALL be ignored in PLL_RESET.
REQ-024 soft_rst and lock loss in the same cycle: soft_rst wins; fail_count still increments.
REQ-025 fail_count SHALL saturate at 255, never wrap.
REQ-026 domain_rstn SHALL be 0 for all bits in PLL_RESET, WAIT_LOCK, STABLE; bits already released SHALL stay high through the rest of RELEASE and RUN.
REQ-027 Counter widths SHALL be derived with $clog2 of the largest parameter; no counter SHALL wrap.
REQ-028 Consumers SHALL re-synchronise each domain_rstn into its own clock; this block does not.

Reset
REQ-029 rstn=0 SHALL asynchronously force: state=PLL_RESET, pll_rst=1, domain_rstn=0, ready=0, fail_count=0, sync flops=0, all counters=0.
REQ-030 After rstn rises, PLL_RESET count SHALL start on the first clkin edge.
REQ-031 rstn assertion mid-RELEASE or RUN SHALL immediately drop all domain_rstn and ready.

Verification (N_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=2)
REQ-032 Nominal: rstn release, pll_locked=1 from cycle 10 -> pll_rst high cycles 1-4, domain_rstn[0] rises after 8 stable cycles, [1] +2, [2] +4, ready +5.
REQ-033 Timeout: pll_locked=0 forever -> pll_rst pulses every 36 cycles, fail_count increments each retry, saturates at 255.
REQ-034 Glitch in STABLE: lock 5 cycles, drop 1, re-lock -> stays WAIT_LOCK/STABLE, release delayed to 8 new stable cycles, fail_count=0.
REQ-035 Lock loss in RUN: pll_locked=0 -> 3 cycles later all domain_rstn=0, ready=0, state=1, fail_count=1.
REQ-036 soft_rst in RELEASE with only domain 0 released -> next cycle domain_rstn=000, state=0, full sequence repeats.
REQ-037 Async reset mid-RUN: rstn low between clock edges -> outputs at reset values before next edge.
